// File: rtl/axis_spi_seq_pkg.sv
// rtl/axis_spi_seq_pkg.sv - shared defaults, state encoding and length clamp for the SPI sequencer
package axis_spi_seq_pkg;

  localparam int SEQ_ADDR_WIDTH = 5;
  localparam int SEQ_GAP_WIDTH  = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_SEND   = ST_SEND,
    S_GAP    = ST_GAP,
    S_FINISH = ST_FINISH
  } seq_state_e;

  // Requested lengths beyond the table depth play the whole table once.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int unsigned aw);
    logic [31:0] lim;
    lim = 32'd1 << aw;
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/axis_spi_seq_ram.sv
// rtl/axis_spi_seq_ram.sv - command table RAM, one write port and one registered read port
module axis_spi_seq_ram
  import axis_spi_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Same-address read and write in one cycle returns the previous contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_spi_sequencer.sv
// rtl/axis_spi_sequencer.sv - plays a RAM table of SPI command words out an AXI-Stream master
// Optional SPI_SEQ_LOOP_EN adds cfg_loop to repeat the table continuously.
module axis_spi_sequencer
  import axis_spi_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int GAP_WIDTH  = SEQ_GAP_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  cfg_start,
`ifdef SPI_SEQ_LOOP_EN
  input  logic                  cfg_loop,
`endif
  input  logic [ADDR_WIDTH:0]   cfg_length,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [ADDR_WIDTH:0]   sts_index
);

  localparam int LW = ADDR_WIDTH + 1;

  seq_state_e           r_state;
  logic [LW-1:0]        r_len;
  logic [LW-1:0]        r_index;
  logic [GAP_WIDTH-1:0] r_gap;
  logic [GAP_WIDTH-1:0] r_gap_cnt;
  logic [31:0]          r_tdata;
  logic                 r_tvalid;
  logic                 r_busy;
  logic                 r_done;

  logic                  w_loop;
  logic                  w_hs;
  logic                  w_last;
  logic [LW-1:0]         w_next_index;
  logic [LW-1:0]         w_len_clamped;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [31:0]           w_rd_data;

`ifdef SPI_SEQ_LOOP_EN
  assign w_loop = cfg_loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_hs          = r_tvalid & m_axis_tready;
  assign w_next_index  = r_index + 1'b1;
  assign w_last        = (w_next_index == r_len);
  assign w_len_clamped = LW'(clamp_len(32'(cfg_length), ADDR_WIDTH));

  // Reads are issued one cycle ahead of FETCH so the RAM output is ready there.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (r_state)
      S_IDLE: begin
        w_rd_en = cfg_start;
      end
      S_SEND: begin
        w_rd_en   = w_hs & ~w_last & (r_gap == '0);
        w_rd_addr = w_next_index[ADDR_WIDTH-1:0];
      end
      S_GAP: begin
        w_rd_en   = (r_gap_cnt == GAP_WIDTH'(1));
        w_rd_addr = r_index[ADDR_WIDTH-1:0];
      end
      S_FINISH: begin
        w_rd_en = r_busy;
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  axis_spi_seq_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_ram (
    .i_clk     (aclk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_index   <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_length != '0) begin
              r_len   <= w_len_clamped;
              r_gap   <= cfg_gap;
              r_index <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_tdata  <= w_rd_data;
          r_tvalid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_tvalid <= 1'b0;
            r_index  <= w_next_index;
            if (w_last) begin
              // Loop mode keeps busy asserted through FINISH into the next pass.
              r_done  <= 1'b1;
              r_busy  <= w_loop;
              r_state <= S_FINISH;
            end else if (r_gap == '0) begin
              r_state <= S_FETCH;
            end else begin
              r_gap_cnt <= r_gap;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_WIDTH'(1)) begin
            r_gap_cnt <= '0;
            r_state   <= S_FETCH;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        S_FINISH: begin
          if (r_busy) begin
            r_index <= '0;
            if (r_gap == '0) begin
              r_state <= S_FETCH;
            end else begin
              r_gap_cnt <= r_gap;
              r_state   <= S_GAP;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign sts_busy      = r_busy;
  assign sts_done      = r_done;
  assign sts_index     = r_index;

endmodule

// File: tb/tb_axis_spi_sequencer.sv
// tb/tb_axis_spi_sequencer.sv - randomized directed bench with a table/timing reference model
module tb_axis_spi_sequencer;

  logic        aclk;
  logic        areset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cfg_start;
`ifdef SPI_SEQ_LOOP_EN
  logic        cfg_loop;
`endif
  logic [5:0]  cfg_length;
  logic [15:0] cfg_gap;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sts_busy;
  logic        sts_done;
  logic [5:0]  sts_index;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int low_cnt = 0;
  int rdy_mode = 0;
  logic [31:0] got_q[$];
  int          hs_q[$];
  logic [31:0] tbl [32];

  axis_spi_sequencer dut (
    .aclk          (aclk),
    .areset        (areset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cfg_start     (cfg_start),
`ifdef SPI_SEQ_LOOP_EN
    .cfg_loop      (cfg_loop),
`endif
    .cfg_length    (cfg_length),
    .cfg_gap       (cfg_gap),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_index     (sts_index)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Sink behaviour: 0 stall, 1 always ready, 2 serializer-like pulse, 3 random, 4 driven by main
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        2: m_axis_tready = m_axis_tvalid && !m_axis_tready;
        3: m_axis_tready = ($urandom_range(0, 1) == 1);
        default: ;
      endcase
    end
  end

  always @(negedge aclk) begin
    cyc++;
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(m_axis_tdata);
        hs_q.push_back(cyc);
      end
      if (sts_done) done_cnt++;
      if (sts_busy) begin
        busy_cnt++;
        if (!m_axis_tvalid) low_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    hs_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    low_cnt  = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
    step();
    wr_en   = 1'b0;
    tbl[a]  = d;
  endtask

  function automatic int words_for(input int len);
    return (len > 32) ? 32 : len;
  endfunction

  task automatic start_seq(input string tag, input int len, input int gap, input int mode);
    rdy_mode = mode;
    clr_mon();
    cfg_length = 6'(len);
    cfg_gap    = 16'(gap);
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
    check({tag, "_busy_start"}, sts_busy, (words_for(len) != 0));
  endtask

  task automatic finish_seq(input string tag, input int len, input int gap, input int mode);
    int exp_n;
    int t;
    int sp_bad;
    exp_n = words_for(len);
    t = 0;
    while (!sts_done && t < 4000) begin
      step();
      t++;
    end
    check({tag, "_timeout"}, (t < 4000), 1);
    repeat (3) step();
    check({tag, "_count"}, got_q.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (i < got_q.size()) check({tag, "_word"}, got_q[i], tbl[i]);
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_idle"}, sts_busy, 0);
    if (exp_n == 0) check({tag, "_nobusy"}, busy_cnt, 0);
    if (mode == 1 && exp_n > 0) begin
      // With a sink that is always ready: each word costs FETCH+SEND, each gap exactly gap cycles.
      check({tag, "_busy_cycles"}, busy_cnt, 2 * exp_n + (exp_n - 1) * gap);
      check({tag, "_low_cycles"}, low_cnt, exp_n + (exp_n - 1) * gap);
      sp_bad = 0;
      for (int i = 1; i < hs_q.size(); i++) begin
        if (hs_q[i] - hs_q[i-1] != gap + 2) sp_bad++;
      end
      check({tag, "_spacing"}, sp_bad, 0);
    end
  endtask

  task automatic run_seq(input string tag, input int len, input int gap, input int mode);
    start_seq(tag, len, gap, mode);
    finish_seq(tag, len, gap, mode);
  endtask

  initial begin
    int t;
    bit ok;
    int len;
    int gap;
    areset     = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    cfg_start  = 1'b0;
    cfg_length = '0;
    cfg_gap    = '0;
`ifdef SPI_SEQ_LOOP_EN
    cfg_loop   = 1'b0;
`endif
    repeat (3) step();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_index", sts_index, 0);
    areset = 1'b0;
    step();

    for (int i = 0; i < 32; i++) wr(i, $urandom());
    wr(0, 32'h1234);
    wr(1, 32'hABCD);
    wr(2, 32'h00FF);

    run_seq("basic", 3, 0, 2);
    check("basic_index", sts_index, 3);

    run_seq("gap5", 3, 5, 1);

    // Backpressure on word 1
    rdy_mode = 4;
    m_axis_tready = 1'b0;
    start_seq("bp", 3, 0, 4);
    t = 0;
    while (!m_axis_tvalid && t < 50) begin step(); t++; end
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    t = 0;
    while (!m_axis_tvalid && t < 50) begin step(); t++; end
    check("bp_word1_seen", m_axis_tvalid, 1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 32'hABCD && sts_index === 6'd1)) ok = 1'b0;
      step();
    end
    check("bp_hold_stable", ok, 1);
    check("bp_data", m_axis_tdata, 32'hABCD);
    check("bp_index", sts_index, 1);
    rdy_mode = 1;
    finish_seq("bp", 3, 0, 4);

    start_seq("len0", 0, 0, 1);
    check("len0_done_next", sts_done, 1);
    finish_seq("len0", 0, 0, 1);

    // Start while busy, plus config changes, must be ignored
    start_seq("ign", 3, 3, 1);
    repeat (4) step();
    cfg_length = 6'd5;
    cfg_gap    = 16'd0;
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
    finish_seq("ign", 3, 3, 1);

    // Rewrite an entry that has not been read yet
    start_seq("wdr", 8, 10, 1);
    t = 0;
    while (got_q.size() < 1 && t < 100) begin step(); t++; end
    wr(7, $urandom());
    finish_seq("wdr", 8, 10, 1);

    run_seq("clamp", 40, 0, 3);
    check("clamp_index", sts_index, 32);

    // Reset while word 10 is presented
    start_seq("rst_mid", 32, 1, 1);
    t = 0;
    while (!(got_q.size() == 10 && m_axis_tvalid) && t < 500) begin step(); t++; end
    check("rst_mid_reached", (t < 500), 1);
    check("rst_mid_index", sts_index, 10);
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("rst_mid_tvalid", m_axis_tvalid, 0);
    check("rst_mid_busy", sts_busy, 0);
    check("rst_mid_idx0", sts_index, 0);
    repeat (6) step();
    check("rst_mid_nomore", got_q.size(), 10);
    check("rst_mid_nodone", done_cnt, 0);
    run_seq("after_rst", 4, 2, 1);

    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) wr($urandom_range(0, 31), $urandom());
      len = $urandom_range(0, 40);
      gap = $urandom_range(0, 4);
      run_seq("rand", len, gap, ($urandom_range(0, 1) == 1) ? 1 : 3);
    end

`ifdef SPI_SEQ_LOOP_EN
    wr(0, $urandom());
    wr(1, $urandom());
    cfg_loop = 1'b1;
    start_seq("loop", 2, 0, 1);
    t = 0;
    while (got_q.size() < 5 && t < 400) begin step(); t++; end
    cfg_loop = 1'b0;
    t = 0;
    while (sts_busy && t < 400) begin step(); t++; end
    repeat (4) step();
    check("loop_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check("loop_word", got_q[i], tbl[i % 2]);
    end
    check("loop_done", done_cnt, 3);
    check("loop_idle", sts_busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
